// File: rtl/para_decoder_pkg.sv
// Shared types, mode constants and one-hot helper for the para_decoder_seq family.
package para_decoder_pkg;

  localparam int unsigned ONEHOT_MAX = 64;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} dec_state_t;

  // One-hot of idx within a width-wide field; all-zero when idx is out of range.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx,
                                                   input int unsigned width);
    logic [ONEHOT_MAX-1:0] r;
    r = '0;
    if (idx < width) r = ONEHOT_MAX'(1) << idx;
    return r;
  endfunction

endpackage

// File: rtl/para_decoder_seq_if.sv
// Handshake/select bus of para_decoder_seq; err exists only with PARA_DECODER_ERR_EN.
interface para_decoder_seq_if #(
  parameter int unsigned IN_WIDTH  = 2,
  parameter int unsigned OUT_WIDTH = 4
);
  logic                 enable;
  logic                 mode;
  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_sel;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out;
  logic                 out_valid;
  logic [IN_WIDTH-1:0]  scan_idx;
`ifdef PARA_DECODER_ERR_EN
  logic                 err;
`endif

  modport master (
    output enable, mode, in_valid, in_sel,
`ifdef PARA_DECODER_ERR_EN
    input  err,
`endif
    input  in_ready, out, out_valid, scan_idx
  );

  modport slave (
    input  enable, mode, in_valid, in_sel,
`ifdef PARA_DECODER_ERR_EN
    output err,
`endif
    output in_ready, out, out_valid, scan_idx
  );

endinterface

// File: rtl/para_decoder_seq_dwell_counter.sv
// Modulo-DWELL counter with synchronous clear; tc_c flags the last count of a dwell.
module dwell_counter #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CW = $clog2(DWELL + 1);

  logic [CW-1:0] count;

  assign tc_c = en && (count == CW'(DWELL - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc_c ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/para_decoder_seq.sv
// Registered N-to-M one-hot decoder with DIRECT (handshake) and SCAN (dwell-stepped) modes.
// Optional err output enabled by defining PARA_DECODER_ERR_EN.
module para_decoder_seq
  import para_decoder_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 2,
  parameter int unsigned OUT_WIDTH = 4,
  parameter int unsigned DWELL     = 4
) (
  input logic              clk,
  input logic              rst,
  para_decoder_seq_if.slave bus
);

  dec_state_t           state;
  logic [OUT_WIDTH-1:0] out_q;
  logic                 out_valid_q;
  logic [IN_WIDTH-1:0]  scan_idx_q;
  logic [IN_WIDTH-1:0]  idx_next;
  logic                 scan_run;
  logic                 dwell_tc;
`ifdef PARA_DECODER_ERR_EN
  logic                 err_q;
`endif

  // Dwell only advances while scanning and staying in SCAN; anything else restarts it.
  assign scan_run = (state == SCAN) && bus.enable && (bus.mode == MODE_SCAN);

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (!scan_run),
    .en    (scan_run),
    .tc_c  (dwell_tc)
  );

  assign idx_next = (scan_idx_q == IN_WIDTH'(OUT_WIDTH - 1)) ? '0 : scan_idx_q + IN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      scan_idx_q  <= '0;
`ifdef PARA_DECODER_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
`ifdef PARA_DECODER_ERR_EN
      err_q       <= 1'b0;
`endif
      if (!bus.enable) begin
        state      <= IDLE;
        out_q      <= '0;
        scan_idx_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.mode == MODE_SCAN) begin
              state       <= SCAN;
              out_q       <= OUT_WIDTH'(onehot(32'd0, OUT_WIDTH));
              scan_idx_q  <= '0;
              out_valid_q <= 1'b1;
            end else begin
              state <= DIRECT;
            end
          end
          DIRECT: begin
            // A mode change wins over a concurrent transfer, which is dropped.
            if (bus.mode != MODE_DIRECT) begin
              state <= IDLE;
              out_q <= '0;
            end else if (bus.in_valid) begin
              out_q       <= OUT_WIDTH'(onehot(32'(bus.in_sel), OUT_WIDTH));
              out_valid_q <= 1'b1;
`ifdef PARA_DECODER_ERR_EN
              err_q       <= (32'(bus.in_sel) >= OUT_WIDTH);
`endif
            end
          end
          SCAN: begin
            if (bus.mode != MODE_SCAN) begin
              state      <= IDLE;
              out_q      <= '0;
              scan_idx_q <= '0;
            end else if (dwell_tc) begin
              scan_idx_q  <= idx_next;
              out_q       <= OUT_WIDTH'(onehot(32'(idx_next), OUT_WIDTH));
              out_valid_q <= 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            out_q      <= '0;
            scan_idx_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = (state == DIRECT);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.scan_idx  = scan_idx_q;
`ifdef PARA_DECODER_ERR_EN
  assign bus.err       = err_q;
`endif

endmodule

// File: tb/tb_para_decoder_seq.sv
// Scoreboard bench for para_decoder_seq: two instances (4 outputs/dwell 3, 3 outputs/dwell 1).
module tb_para_decoder_seq;

  logic clk;
  logic rst;

  para_decoder_seq_if #(.IN_WIDTH(2), .OUT_WIDTH(4)) bus_a ();
  para_decoder_seq_if #(.IN_WIDTH(2), .OUT_WIDTH(3)) bus_b ();

  para_decoder_seq #(.IN_WIDTH(2), .OUT_WIDTH(4), .DWELL(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  para_decoder_seq #(.IN_WIDTH(2), .OUT_WIDTH(3), .DWELL(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] out;
    logic [1:0] idx;
    logic       err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int passed = 0;
  int total  = 0;

  // Reference model: phase 0 idle, 1 direct, 2 scan; t counts cycles since scan entry.
  int         ow[2] = '{4, 3};
  int         dw[2] = '{3, 1};
  int         ph[2];
  int         t[2];
  logic [3:0] m_out[2];
  logic [1:0] m_idx[2];
  logic       m_rdy[2];
  logic       m_vld[2];
  logic       m_err[2];

  function automatic void chk(string name, int k, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, k, act, exp, $time);
  endfunction

  function automatic void model_step(int k, logic r, logic e, logic m, logic v, logic [1:0] s);
    logic vld;
    logic er;
    int   sel;
    vld = 1'b0;
    er  = 1'b0;
    sel = int'(s);
    if (r || !e) begin
      ph[k] = 0; m_out[k] = '0; m_idx[k] = '0;
    end else if (ph[k] == 0) begin
      if (m) begin
        ph[k] = 2; t[k] = 0; m_idx[k] = '0; m_out[k] = 4'b0001; vld = 1'b1;
      end else begin
        ph[k] = 1;
      end
    end else if (ph[k] == 1) begin
      if (m) begin
        ph[k] = 0; m_out[k] = '0;
      end else if (v) begin
        m_out[k] = (sel < ow[k]) ? (4'(1) << sel) : 4'b0000;
        er  = (sel >= ow[k]);
        vld = 1'b1;
      end
    end else begin
      if (!m) begin
        ph[k] = 0; m_out[k] = '0; m_idx[k] = '0;
      end else begin
        t[k]++;
        vld      = ((t[k] % dw[k]) == 0);
        m_idx[k] = 2'((t[k] / dw[k]) % ow[k]);
        m_out[k] = 4'(1) << m_idx[k];
      end
    end
    m_vld[k] = vld;
    m_err[k] = er;
    m_rdy[k] = (ph[k] == 1);
    if (vld) begin
      if (k == 0) q_a.push_back('{out: m_out[k], idx: m_idx[k], err: er});
      else        q_b.push_back('{out: m_out[k], idx: m_idx[k], err: er});
    end
  endfunction

  task automatic cyc(input logic r, input logic e, input logic m, input logic v,
                     input logic [1:0] s);
    rst = r;
    bus_a.enable = e; bus_a.mode = m; bus_a.in_valid = v; bus_a.in_sel = s;
    bus_b.enable = e; bus_b.mode = m; bus_b.in_valid = v; bus_b.in_sel = s;
    @(posedge clk);
    model_step(0, r, e, m, v, s);
    model_step(1, r, e, m, v, s);
    #1;
  endtask

  function automatic void check_dut(int k);
    logic [3:0] o;
    logic [1:0] si;
    logic       rdy;
    logic       ov;
    logic       er;
    exp_t       e;
    er = 1'b0;
    if (k == 0) begin
      o = bus_a.out; si = bus_a.scan_idx; rdy = bus_a.in_ready; ov = bus_a.out_valid;
`ifdef PARA_DECODER_ERR_EN
      er = bus_a.err;
`endif
    end else begin
      o = {1'b0, bus_b.out}; si = bus_b.scan_idx; rdy = bus_b.in_ready; ov = bus_b.out_valid;
`ifdef PARA_DECODER_ERR_EN
      er = bus_b.err;
`endif
    end
`ifdef PARA_DECODER_ERR_EN
    chk("level{out,idx,rdy,vld,err}", k, 16'({o, si, rdy, ov, er}),
        16'({m_out[k], m_idx[k], m_rdy[k], m_vld[k], m_err[k]}));
`else
    chk("level{out,idx,rdy,vld}", k, 16'({o, si, rdy, ov}),
        16'({m_out[k], m_idx[k], m_rdy[k], m_vld[k]}));
`endif
    if (ov) begin
      if ((k == 0 && q_a.size() == 0) || (k == 1 && q_b.size() == 0)) begin
        chk("unexpected_out_valid", k, 16'(1), 16'(0));
      end else begin
        e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
`ifndef PARA_DECODER_ERR_EN
        e.err = 1'b0;
`endif
        chk("payload{out,idx,err}", k, 16'({o, si, er}), 16'(e));
      end
    end
  endfunction

  initial begin
    @(posedge clk);
    forever begin
      #2;
      check_dut(0);
      check_dut(1);
      @(posedge clk);
    end
  end

  initial begin
    ph = '{0, 0}; t = '{0, 0};
    m_out = '{4'b0, 4'b0}; m_idx = '{2'b0, 2'b0};
    m_rdy = '{1'b0, 1'b0}; m_vld = '{1'b0, 1'b0}; m_err = '{1'b0, 1'b0};

    // Reset held with enable/scan requested, then scan starts at channel 0.
    repeat (2) cyc(1, 1, 1, 0, 0);
    repeat (3) cyc(0, 1, 1, 0, 0);
    // Switch to DIRECT and stream 2, 3, 0 back to back.
    repeat (2) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 2);
    cyc(0, 1, 0, 1, 3);
    cyc(0, 1, 0, 1, 0);
    repeat (2) cyc(0, 1, 0, 0, 0);
    // Code 3 is out of range for the 3-output instance.
    cyc(0, 1, 0, 1, 3);
    cyc(0, 1, 0, 1, 1);
    cyc(0, 1, 0, 0, 0);
    // Mode change coinciding with a transfer, followed by a full wrap.
    cyc(0, 1, 1, 1, 1);
    repeat (14) cyc(0, 1, 1, 0, 0);
    // Disable mid-scan at channel 2, then restart.
    cyc(0, 0, 1, 0, 0);
    repeat (7) cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (4) cyc(0, 1, 1, 0, 0);
    // Reset mid-scan.
    cyc(1, 1, 1, 0, 0);
    repeat (2) cyc(0, 1, 1, 0, 0);

    begin
      logic m;
      logic e;
      m = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 11) == 0) m = ~m;
        e = ($urandom_range(0, 19) != 0);
        cyc(($urandom_range(0, 99) == 0), e, m, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)));
      end
    end

    #5;
    chk("drain_queue", 0, 16'(q_a.size()), 16'(0));
    chk("drain_queue", 1, 16'(q_b.size()), 16'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/para_decoder_seq.md
Name: para_decoder_seq

Overview:
- Registered, parametrised N-to-M one-hot decoder; the sequential successor to the combinational parameterised decoder.
- Two modes:
  - DIRECT: decodes a code accepted over a valid/ready handshake.
  - SCAN: an internal counter steps the one-hot output through all channels, holding each for a programmable dwell time.
- Used as a channel/row-select generator ahead of muxes, LED/keypad scanners and bank selects.

Parameters:
- IN_WIDTH, 2, width of the input code and of scan_idx.
- OUT_WIDTH, 4, number of one-hot outputs; legal range 2..2**IN_WIDTH.
- DWELL, 4, cycles each channel is held in SCAN mode; must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  block enable; low forces the IDLE state.
- mode  input  1  0 = DIRECT, 1 = SCAN; sampled every cycle.
- in_valid  input  1  in_sel is valid.
- in_sel  input  IN_WIDTH  code to decode in DIRECT mode.
- in_ready  output  1  block accepts in_sel this cycle.
- out  output  OUT_WIDTH  registered one-hot (or all-zero) select.
- out_valid  output  1  one-cycle pulse whenever out takes a new value.
- scan_idx  output  IN_WIDTH  index of the active channel in SCAN mode; 0 otherwise.
- err  output  1  present only with the optional feature (see below).

Behaviour:
- Reset: rst is synchronous and active-high and wins over every other input. All of the following hold in the cycle after rst is sampled high:
  - state = IDLE
  - out = 0, out_valid = 0, in_ready = 0
  - scan_idx = 0, dwell counter = 0, err = 0
- States: IDLE, DIRECT, SCAN. Encoding is a 2-bit enum.
- IDLE:
  - Outputs: out = 0, in_ready = 0.
  - enable=1 & mode=0 -> DIRECT.
  - enable=1 & mode=1 -> SCAN. On entry: out = one-hot bit 0, scan_idx = 0, dwell counter = 0, out_valid pulses.
- DIRECT:
  - in_ready = 1, combinational from state only.
  - Transfer occurs when in_valid & in_ready. The next cycle has out = 1 << in_sel and out_valid = 1 for one cycle. Latency is 1 clock.
  - With no transfer, out holds its previous value and out_valid = 0.
  - Out-of-range code (in_sel >= OUT_WIDTH): out = 0 and out_valid still pulses.
  - Back-to-back transfers are legal every cycle at full throughput.
- SCAN:
  - in_ready = 0; in_valid is ignored.
  - The dwell counter counts 0..DWELL-1. At DWELL-1 it clears, scan_idx advances by 1, out moves to the next one-hot bit, and out_valid pulses.
  - Wrap: from scan_idx = OUT_WIDTH-1 the next step is 0. Indices >= OUT_WIDTH are never produced.
  - DWELL = 1: the output advances every cycle and out_valid is constantly 1.
- Exits and mode changes:
  - enable=0 in any state -> IDLE next cycle, with out = 0, out_valid = 0 and the dwell counter/scan_idx cleared.
  - A mode change while enabled passes through IDLE for exactly one cycle (out = 0), then enters the new mode as described above.
  - A mode change in the same cycle as a DIRECT transfer: the transfer is discarded and no out_valid pulse is produced.
- Reset mid-scan or mid-transfer: IDLE next cycle; no partial output.
- Width rules:
  - scan_idx wrap compare is done at IN_WIDTH bits.
  - Dwell counter width is $clog2(DWELL+1).

Optional Feature:
- Macro PARA_DECODER_ERR_EN.
- Defined:
  - The err port exists.
  - err pulses high for one cycle, aligned with out_valid, when a DIRECT transfer carries in_sel >= OUT_WIDTH.
  - err is 0 at reset and in all other cases.
- Undefined:
  - No err port and no error logic.
  - Out-of-range codes silently yield out = 0 with out_valid pulsing.

Decomposition:
- Shared package para_decoder_pkg holds:
  - typedef enum logic [1:0] {IDLE, DIRECT, SCAN} dec_state_t
  - the MODE_DIRECT / MODE_SCAN constants
  - a function onehot(idx) returning the OUT_WIDTH-wide one-hot (zero if out of range)
- One natural sub-module: dwell_counter, a parametrised modulo-DWELL counter with a clear input and a terminal-count pulse output.

Test Plan (IN_WIDTH=2, OUT_WIDTH=4, DWELL=3 unless noted):
1. Reset: rst=1 for 2 cycles with enable=1, mode=1 -> out=0000, out_valid=0, scan_idx=0, in_ready=0; after rst drops, SCAN entered with out=0001.
2. DIRECT handshake: enable=1, mode=0, in_valid=1, in_sel=2, then 3, then 0 on consecutive cycles -> out = 0100, 1000, 0001 one cycle after each transfer, out_valid high 3 consecutive cycles.
3. SCAN wrap: mode=1 for 14 cycles -> out sequence 0001 x3, 0010 x3, 0100 x3, 1000 x3, 0001; scan_idx sequence 0,1,2,3,0; out_valid pulses every 3rd cycle.
4. Out of range: OUT_WIDTH=3, DIRECT in_sel=3 -> out=000 and out_valid=1; with PARA_DECODER_ERR_EN, err=1 in the same cycle.
5. Disable mid-scan: enable drops at scan_idx=2 -> next cycle IDLE, out=0000, scan_idx=0; re-enable restarts at 0001.
6. Mode switch during transfer: mode 0->1 in the same cycle as in_valid with in_sel=1 -> no out_valid for code 1, one IDLE cycle with out=0000, then SCAN with out=0001.
